// File: rtl/alu_pkg.sv
// Shared opcode encoding and default width for the registered 8-bit ALU.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_ADC   = 4'd1,
    OP_SUB   = 4'd2,
    OP_SBB   = 4'd3,
    OP_INC   = 4'd4,
    OP_DEC   = 4'd5,
    OP_PASSA = 4'd6,
    OP_PASSB = 4'd7,
    OP_AND   = 4'd8,
    OP_OR    = 4'd9,
    OP_XOR   = 4'd10,
    OP_NOTA  = 4'd11,
    OP_SHL   = 4'd12,
    OP_SHR   = 4'd13,
    OP_ROL   = 4'd14,
    OP_ROR   = 4'd15
  } alu_op_e;

endpackage

// File: rtl/alu_datapath.sv
// Combinational ALU core: result, carry/borrow/shifted-out bit and zero flag.
module alu_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic [3:0]       sel,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             zero
);

  // Top bit of r is the carry, borrow or shifted-out bit; zero for logic ops.
  logic [WIDTH:0] r;
  logic [WIDTH:0] a_x;
  logic [WIDTH:0] b_x;
  logic [WIDTH:0] c_x;
  logic [WIDTH:0] one_x;

  assign a_x   = {1'b0, a};
  assign b_x   = {1'b0, b};
  assign c_x   = {{WIDTH{1'b0}}, c_in};
  assign one_x = {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    r = '0;
    case (alu_op_e'(sel))
      OP_ADD:   r = a_x + b_x;
      OP_ADC:   r = a_x + b_x + c_x;
      OP_SUB:   r = a_x - b_x;
      OP_SBB:   r = a_x - b_x - c_x;
      OP_INC:   r = a_x + one_x;
      OP_DEC:   r = a_x - one_x;
      OP_PASSA: r = a_x;
      OP_PASSB: r = b_x;
      OP_AND:   r = {1'b0, a & b};
      OP_OR:    r = {1'b0, a | b};
      OP_XOR:   r = {1'b0, a ^ b};
      OP_NOTA:  r = {1'b0, ~a};
      OP_SHL:   r = {a, 1'b0};
      OP_SHR:   r = {a[0], 1'b0, a[WIDTH-1:1]};
      OP_ROL:   r = {a[WIDTH-1], a[WIDTH-2:0], a[WIDTH-1]};
      OP_ROR:   r = {a[0], a[0], a[WIDTH-1:1]};
      default:  r = '0;
    endcase
  end

  assign y     = r[WIDTH-1:0];
  assign carry = r[WIDTH];
  assign zero  = (r[WIDTH-1:0] == '0);

endmodule

// File: rtl/alu.sv
// Registered ALU top: one-cycle latency, async active-low reset.
// Define ALU_FLAGS_EN to add the registered alu_c_out and alu_z flag outputs.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             alu_clk,
  input  logic             alu_rst_n,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic             alu_c_in,
  input  logic [3:0]       alu_sel,
`ifdef ALU_FLAGS_EN
  output logic             alu_c_out,
  output logic             alu_z,
`endif
  output logic [WIDTH-1:0] alu_y
);

  logic [WIDTH-1:0] y_next;

`ifdef ALU_FLAGS_EN
  logic c_next;
  logic z_next;
`else
  logic c_next_unused;
  logic z_next_unused;
`endif

  alu_datapath #(.WIDTH(WIDTH)) u_datapath (
    .a     (alu_a),
    .b     (alu_b),
    .c_in  (alu_c_in),
    .sel   (alu_sel),
    .y     (y_next),
`ifdef ALU_FLAGS_EN
    .carry (c_next),
    .zero  (z_next)
`else
    .carry (c_next_unused),
    .zero  (z_next_unused)
`endif
  );

  always_ff @(posedge alu_clk or negedge alu_rst_n) begin
    if (!alu_rst_n) begin
      alu_y <= '0;
    end else begin
      alu_y <= y_next;
    end
  end

`ifdef ALU_FLAGS_EN
  always_ff @(posedge alu_clk or negedge alu_rst_n) begin
    if (!alu_rst_n) begin
      alu_c_out <= 1'b0;
      alu_z     <= 1'b0;
    end else begin
      alu_c_out <= c_next;
      alu_z     <= z_next;
    end
  end
`endif

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the registered ALU (flag checks when ALU_FLAGS_EN is defined).
module tb_alu;

  logic       alu_clk;
  logic       alu_rst_n;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic       alu_c_in;
  logic [3:0] alu_sel;
  logic [7:0] alu_y;
`ifdef ALU_FLAGS_EN
  logic       alu_c_out;
  logic       alu_z;
`endif

  int checks = 0;
  int errors = 0;

  alu #(.WIDTH(8)) dut (
    .alu_clk   (alu_clk),
    .alu_rst_n (alu_rst_n),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_c_in  (alu_c_in),
    .alu_sel   (alu_sel),
`ifdef ALU_FLAGS_EN
    .alu_c_out (alu_c_out),
    .alu_z     (alu_z),
`endif
    .alu_y     (alu_y)
  );

  initial alu_clk = 1'b0;
  always #5 alu_clk = ~alu_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge alu_clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic c, input logic [3:0] s);
    alu_a    = a;
    alu_b    = b;
    alu_c_in = c;
    alu_sel  = s;
  endtask

  // A=3, B=10, c_in=1
  logic [7:0] sweep_y [16] = '{8'h0D, 8'h0E, 8'hF9, 8'hF8, 8'h04, 8'h02, 8'h03, 8'h0A,
                               8'h02, 8'h0B, 8'h09, 8'hFC, 8'h06, 8'h01, 8'h06, 8'h81};
  logic       sweep_c [16] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    alu_rst_n = 1'b0;
    drive(8'h03, 8'h0A, 1'b1, 4'd0);
    #12;
    chk("reset_y", alu_y, 8'h00);
`ifdef ALU_FLAGS_EN
    chk("reset_c", alu_c_out, 1'b0);
    chk("reset_z", alu_z, 1'b0);
`endif
    alu_rst_n = 1'b1;
    step();

    for (int i = 0; i < 16; i++) begin
      drive(8'h03, 8'h0A, 1'b1, 4'(i));
      repeat (3) step();
      chk($sformatf("sweep_y_op%0d", i), alu_y, sweep_y[i]);
`ifdef ALU_FLAGS_EN
      chk($sformatf("sweep_c_op%0d", i), alu_c_out, sweep_c[i]);
      chk($sformatf("sweep_z_op%0d", i), alu_z, 1'b0);
`endif
    end

    // Mid-cycle reset while alu_y holds 0x81
    #3;
    alu_rst_n = 1'b0;
    #1;
    chk("midreset_y", alu_y, 8'h00);
`ifdef ALU_FLAGS_EN
    chk("midreset_c", alu_c_out, 1'b0);
`endif
    #2;
    alu_rst_n = 1'b1;

    drive(8'h03, 8'h0A, 1'b1, 4'd0);
    step();
    chk("lat_add", alu_y, 8'h0D);
    alu_sel = 4'd8;
    #3;
    chk("lat_hold", alu_y, 8'h0D);
    step();
    chk("lat_and", alu_y, 8'h02);

    drive(8'hFF, 8'h01, 1'b0, 4'd0);
    step();
    chk("wrap_add_y", alu_y, 8'h00);
`ifdef ALU_FLAGS_EN
    chk("wrap_add_c", alu_c_out, 1'b1);
    chk("wrap_add_z", alu_z, 1'b1);
`endif
    drive(8'h00, 8'h01, 1'b0, 4'd5);
    step();
    chk("wrap_dec_y", alu_y, 8'hFF);
`ifdef ALU_FLAGS_EN
    chk("wrap_dec_c", alu_c_out, 1'b1);
    chk("wrap_dec_z", alu_z, 1'b0);
`endif

    drive(8'h0A, 8'h03, 1'b1, 4'd3);
    step();
    chk("sbb_y", alu_y, 8'h06);
`ifdef ALU_FLAGS_EN
    chk("sbb_c", alu_c_out, 1'b0);
`endif
    drive(8'h03, 8'h0A, 1'b0, 4'd1);
    step();
    chk("adc_cin0", alu_y, 8'h0D);
    drive(8'h03, 8'h0A, 1'b1, 4'd1);
    step();
    chk("adc_cin1", alu_y, 8'h0E);
    drive(8'h03, 8'h0A, 1'b1, 4'd0);
    step();
    chk("add_ignores_cin", alu_y, 8'h0D);

    drive(8'h80, 8'h00, 1'b0, 4'd12);
    step();
    chk("shl_y", alu_y, 8'h00);
`ifdef ALU_FLAGS_EN
    chk("shl_c", alu_c_out, 1'b1);
    chk("shl_z", alu_z, 1'b1);
`endif
    drive(8'h80, 8'h00, 1'b0, 4'd14);
    step();
    chk("rol_y", alu_y, 8'h01);
`ifdef ALU_FLAGS_EN
    chk("rol_c", alu_c_out, 1'b1);
`endif
    drive(8'h80, 8'h00, 1'b0, 4'd13);
    step();
    chk("shr_y", alu_y, 8'h40);
`ifdef ALU_FLAGS_EN
    chk("shr_c", alu_c_out, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
